btb_predictor: RTL and testbench

Branch target buffer with 2-bit saturating direction counters, sitting directly upstream of the fetch stage. Every cycle it takes the current fetch PC and returns the predicted next fetch address, which fetch carries down the pipe as `address_predicted`. It learns from resolved control-flow outcomes reported back by the execute stage, and keeps branch and mispredict performance counters.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/bp_sat_ctr.sv | 22 ++
 rtl/btb_predictor.sv | 105 ++++++++++
 tb/tb_btb_predictor.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants and types for the branch prediction logic.
// The counter encoding is read as: high bit set means "predict taken".
package cpu_pkg;

  localparam logic [31:0] PC_INCREMENT = 32'd4;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_t;

  localparam ctr_t CTR_RESET = CTR_WNT;
  localparam ctr_t CTR_ALLOC = CTR_WT;

  function automatic logic ctr_predicts_taken(input ctr_t c);
    return c[1];
  endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// Next-state function of a 2-bit saturating direction counter.
module bp_sat_ctr
  import cpu_pkg::*;
(
  input  ctr_t ctr,
  input  logic taken,
  output ctr_t ctr_next
);

  // Move one step toward the observed outcome, holding at either end.
  always_comb begin
    ctr_next = ctr;
    unique case (ctr)
      CTR_SNT: ctr_next = taken ? CTR_WNT : CTR_SNT;
      CTR_WNT: ctr_next = taken ? CTR_WT  : CTR_SNT;
      CTR_WT:  ctr_next = taken ? CTR_ST  : CTR_WNT;
      CTR_ST:  ctr_next = taken ? CTR_ST  : CTR_WT;
      default: ctr_next = ctr;
    endcase
  end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters feeding fetch,
// trained by resolved outcomes from execute, plus branch/mispredict counters.
module btb_predictor
  import cpu_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] lookup_pc,
  output logic [31:0] pred_next,
  output logic        pred_taken,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispredict,
  input  logic        clear,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  localparam int N     = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;

  logic             valid   [N];
  logic [TAG_W-1:0] tag_mem [N];
  logic [29:0]      tgt_mem [N];
  ctr_t             ctr_mem [N];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;

  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  ctr_t             up_ctr_cur;
  ctr_t             up_ctr_next;

  logic unused_low_bits;

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[31:IDX_W+2];
  assign lk_hit = valid[lk_idx] && (tag_mem[lk_idx] == lk_tag);

  // Lookup reads the registered table only, so a same-index update lands next cycle.
  assign pred_taken = lk_hit && ctr_predicts_taken(ctr_mem[lk_idx]);
  assign pred_next  = pred_taken ? {tgt_mem[lk_idx], 2'b00} : (lookup_pc + PC_INCREMENT);

  assign up_idx     = upd_pc[IDX_W+1:2];
  assign up_tag     = upd_pc[31:IDX_W+2];
  assign up_hit     = valid[up_idx] && (tag_mem[up_idx] == up_tag);
  assign up_ctr_cur = ctr_mem[up_idx];

  assign unused_low_bits = ^{upd_pc[1:0], upd_target[1:0]};

  bp_sat_ctr u_sat_ctr (
    .ctr      (up_ctr_cur),
    .taken    (upd_taken),
    .ctr_next (up_ctr_next)
  );

  // Table training; clear takes priority over any same-cycle allocation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        valid[i]   <= 1'b0;
        tag_mem[i] <= '0;
        tgt_mem[i] <= '0;
        ctr_mem[i] <= CTR_RESET;
      end
    end else if (clear) begin
      for (int i = 0; i < N; i++) begin
        valid[i] <= 1'b0;
      end
    end else if (upd_valid) begin
      if (up_hit) begin
        ctr_mem[up_idx] <= up_ctr_next;
        if (upd_taken) begin
          tgt_mem[up_idx] <= upd_target[31:2];
        end
      end else if (upd_taken) begin
        valid[up_idx]   <= 1'b1;
        tag_mem[up_idx] <= up_tag;
        tgt_mem[up_idx] <= upd_target[31:2];
        ctr_mem[up_idx] <= CTR_ALLOC;
      end
    end
  end

  // Performance counters see every reported update, cleared table or not.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (upd_valid) begin
      branch_count <= branch_count + 32'd1;
      if (upd_mispredict) begin
        mispredict_count <= mispredict_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_btb_predictor.sv
// Self-checking bench for btb_predictor: directed scenarios followed by random
// traffic compared against an address-keyed behavioural model.
module tb_btb_predictor;

  localparam int IDX_W = 4;
  localparam int N     = 1 << IDX_W;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] lookup_pc;
  logic [31:0] pred_next;
  logic        pred_taken;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;
  logic        clear;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int testCount = 0;
  int failCount = 0;

  bit          mValid [N];
  logic [29:0] mWord  [N];
  logic [29:0] mTgt   [N];
  int          mCtr   [N];
  logic [31:0] mBranch;
  logic [31:0] mMiss;

  logic [31:0] tagPool [4];

  btb_predictor #(.IDX_W(IDX_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .lookup_pc        (lookup_pc),
    .pred_next        (pred_next),
    .pred_taken       (pred_taken),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_mispredict   (upd_mispredict),
    .clear            (clear),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  function automatic int slotOf(input logic [31:0] pc);
    return int'((pc >> 2) % N);
  endfunction

  function automatic bit expTaken(input logic [31:0] pc);
    int s;
    s = slotOf(pc);
    return mValid[s] && (mWord[s] == pc[31:2]) && (mCtr[s] >= 2);
  endfunction

  function automatic logic [31:0] expNext(input logic [31:0] pc);
    int s;
    s = slotOf(pc);
    if (expTaken(pc)) return {mTgt[s], 2'b00};
    return pc + 32'd4;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < N; i++) begin
      mValid[i] = 1'b0;
      mCtr[i]   = 1;
    end
    mBranch = 0;
    mMiss   = 0;
  endtask

  task automatic modelUpdate(input logic uv, input logic [31:0] upc, input logic ut,
                             input logic [31:0] utgt, input logic um, input logic clr);
    int s;
    s = slotOf(upc);
    if (uv) begin
      mBranch = mBranch + 1;
      if (um) mMiss = mMiss + 1;
    end
    if (clr) begin
      for (int i = 0; i < N; i++) mValid[i] = 1'b0;
    end else if (uv) begin
      if (mValid[s] && mWord[s] == upc[31:2]) begin
        mCtr[s] = ut ? ((mCtr[s] < 3) ? mCtr[s] + 1 : 3) : ((mCtr[s] > 0) ? mCtr[s] - 1 : 0);
        if (ut) mTgt[s] = utgt[31:2];
      end else if (ut) begin
        mValid[s] = 1'b1;
        mWord[s]  = upc[31:2];
        mTgt[s]   = utgt[31:2];
        mCtr[s]   = 2;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic checkPrediction(input string tag);
    checkOutput({tag, "_next"}, pred_next, expNext(lookup_pc));
    checkOutput({tag, "_taken"}, {31'b0, pred_taken}, {31'b0, expTaken(lookup_pc)});
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, "_branch_count"}, branch_count, mBranch);
    checkOutput({tag, "_mispredict_count"}, mispredict_count, mMiss);
  endtask

  // One clock of traffic: prediction checked before the edge, counters after it.
  task automatic applyStimulus(input logic [31:0] lpc, input logic uv, input logic [31:0] upc,
                               input logic ut, input logic [31:0] utgt, input logic um,
                               input logic clr);
    lookup_pc      = lpc;
    upd_valid      = uv;
    upd_pc         = upc;
    upd_taken      = ut;
    upd_target     = utgt;
    upd_mispredict = um;
    clear          = clr;
    #1;
    checkPrediction("step");
    @(posedge clk);
    modelUpdate(uv, upc, ut, utgt, um, clr);
    #1;
    upd_valid = 1'b0;
    clear     = 1'b0;
    checkCounters("step");
  endtask

  task automatic lookupCheck(input string tag, input logic [31:0] lpc, input logic [31:0] literal);
    lookup_pc = lpc;
    upd_valid = 1'b0;
    clear     = 1'b0;
    #1;
    checkOutput(tag, pred_next, literal);
    checkPrediction(tag);
  endtask

  task automatic doReset(input logic [31:0] lpc);
    lookup_pc = lpc;
    upd_valid = 1'b0;
    clear     = 1'b0;
    reset     = 1'b1;
    modelReset();
    #1;
    checkOutput("reset_next", pred_next, lpc + 32'd4);
    checkOutput("reset_taken", {31'b0, pred_taken}, 32'd0);
    checkOutput("reset_branch_count", branch_count, 32'd0);
    checkOutput("reset_mispredict_count", mispredict_count, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tagPool[0] = 32'h0000_0000;
    tagPool[1] = 32'h0000_0001;
    tagPool[2] = 32'h0000_0005;
    tagPool[3] = 32'h03FF_FFFF;
    upd_pc         = '0;
    upd_taken      = 1'b0;
    upd_target     = '0;
    upd_mispredict = 1'b0;

    doReset(32'h100);

    // Allocation observed in the same cycle shows the old state, then the target.
    applyStimulus(32'h40, 1'b1, 32'h40, 1'b1, 32'h200, 1'b0, 1'b0);
    lookupCheck("alloc_hit", 32'h40, 32'h200);
    checkOutput("alloc_taken", {31'b0, pred_taken}, 32'd1);
    lookupCheck("alias_miss", 32'h80, 32'h84);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
      lookupCheck("sat_down", 32'h40, 32'h44);
    end
    applyStimulus(32'h40, 1'b1, 32'h40, 1'b1, 32'h200, 1'b0, 1'b0);
    lookupCheck("hyst_wnt", 32'h40, 32'h44);
    applyStimulus(32'h40, 1'b1, 32'h40, 1'b1, 32'h200, 1'b0, 1'b0);
    lookupCheck("hyst_wt", 32'h40, 32'h200);

    applyStimulus(32'h60, 1'b1, 32'h60, 1'b1, 32'h300, 1'b0, 1'b1);
    lookupCheck("clear_alloc", 32'h60, 32'h64);
    lookupCheck("clear_old", 32'h40, 32'h44);
    checkOutput("clear_branch_count", branch_count, 32'd7);

    doReset(32'h0);
    applyStimulus(32'h0, 1'b1, 32'h10, 1'b1, 32'h400, 1'b1, 1'b0);
    applyStimulus(32'h0, 1'b1, 32'h14, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(32'h0, 1'b1, 32'h10, 1'b1, 32'h400, 1'b0, 1'b0);
    applyStimulus(32'h0, 1'b1, 32'h18, 1'b1, 32'h500, 1'b1, 1'b0);
    applyStimulus(32'h0, 1'b1, 32'h1C, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("perf_branch_count", branch_count, 32'd5);
    checkOutput("perf_mispredict_count", mispredict_count, 32'd2);
    lookupCheck("wrap_next", 32'hFFFF_FFFC, 32'h0000_0000);

    // Reset arriving while an update is on the wires must discard it.
    lookup_pc      = 32'h20;
    upd_valid      = 1'b1;
    upd_pc         = 32'h20;
    upd_taken      = 1'b1;
    upd_target     = 32'h800;
    upd_mispredict = 1'b1;
    #2;
    reset = 1'b1;
    modelReset();
    #1;
    checkCounters("midreset");
    @(posedge clk);
    #1;
    checkCounters("midreset_edge");
    upd_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    lookupCheck("midreset_lookup", 32'h20, 32'h24);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] lpc;
      logic [31:0] upc;
      lpc = (tagPool[$urandom_range(0, 3)] << (IDX_W + 2)) | ($urandom_range(0, N - 1) << 2)
            | $urandom_range(0, 3);
      upc = (tagPool[$urandom_range(0, 3)] << (IDX_W + 2)) | ($urandom_range(0, N - 1) << 2)
            | $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) lpc = upc;
      applyStimulus(lpc, 1'($urandom_range(0, 3) != 0), upc, 1'($urandom_range(0, 2) != 0),
                    $urandom, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 40) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
